// File: rtl/seg7_scan_capture.sv
// Receive side of the 4-digit multiplexed seven-segment bus: samples anode/cathode,
// filters for stability, decodes each digit and reassembles the displayed 16-bit value.
module seg7_scan_capture #(
  parameter int STABLE_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  anode,
  input  logic [7:0]  cathode,
  output logic [15:0] value,
  output logic        value_valid,
  output logic        digit_err,
  output logic        multi_err,
  output logic        timeout
);

  localparam logic [3:0]  RUN_MAX  = 4'(STABLE_CYCLES);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  // COLLECT exactly when at least one slot of the current frame has been seen.
  typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;
  state_t state, state_nxt;

  logic [3:0]       s_anode;
  logic [7:0]       s_cathode;
  logic [3:0]       run_len, run_nxt;
  logic             acc, acc_nxt;
  logic [3:0]       seen, seen_nxt;
  logic [3:0][3:0]  slot, slot_nxt;
  logic [15:0]      idle_cnt, idle_nxt;
  logic [15:0]      value_nxt;
  logic             vv_nxt, de_nxt, me_nxt, to_nxt;

  logic             changed, pat_ok, single, multi;
  logic [3:0]       nib;
  logic [1:0]       idx;

  always_comb begin
    nib    = 4'h0;
    pat_ok = 1'b1;
    case (s_cathode)
      8'h03: nib = 4'h0;
      8'h9F: nib = 4'h1;
      8'h25: nib = 4'h2;
      8'h0D: nib = 4'h3;
      8'h99: nib = 4'h4;
      8'h49: nib = 4'h5;
      8'h41: nib = 4'h6;
      8'h1F: nib = 4'h7;
      8'h01: nib = 4'h8;
      8'h09: nib = 4'h9;
      8'hFF: nib = 4'hF;
      default: pat_ok = 1'b0;
    endcase
  end

  always_comb begin
    idx = 2'd0;
    case (s_anode)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  assign single  = $onehot(~s_anode);
  assign multi   = !single && (s_anode != 4'hF);
  assign changed = ({anode, cathode} != {s_anode, s_cathode});

  // acc marks the single cycle in which the current run first reaches RUN_MAX.
  always_comb begin
    run_nxt = changed ? 4'd1 : ((run_len == RUN_MAX) ? RUN_MAX : run_len + 4'd1);
    acc_nxt = (run_nxt == RUN_MAX) && (changed || (run_len != RUN_MAX));
  end

  always_comb begin
    seen_nxt  = seen;
    slot_nxt  = slot;
    idle_nxt  = idle_cnt;
    value_nxt = value;
    vv_nxt    = 1'b0;
    de_nxt    = 1'b0;
    me_nxt    = 1'b0;
    to_nxt    = 1'b0;
    if (acc && multi) begin
      me_nxt   = 1'b1;
      seen_nxt = 4'b0000;
      idle_nxt = 16'd0;
    end else if (acc && single && !pat_ok) begin
      // An error pulse owns this cycle, so a due timeout is deferred by one accept.
      de_nxt = 1'b1;
      if (state == IDLE)
        idle_nxt = 16'd0;
      else if (idle_cnt != TO_LAST)
        idle_nxt = idle_cnt + 16'd1;
    end else if (acc && single) begin
      slot_nxt[idx] = nib;
      seen_nxt[idx] = 1'b1;
      idle_nxt      = 16'd0;
      if (seen_nxt == 4'b1111) begin
        value_nxt = slot_nxt;
        vv_nxt    = 1'b1;
        seen_nxt  = 4'b0000;
      end
    end else if (state == COLLECT) begin
      if (idle_cnt == TO_LAST) begin
        to_nxt   = 1'b1;
        seen_nxt = 4'b0000;
        idle_nxt = 16'd0;
      end else begin
        idle_nxt = idle_cnt + 16'd1;
      end
    end else begin
      idle_nxt = 16'd0;
    end
    state_nxt = (seen_nxt != 4'b0000) ? COLLECT : IDLE;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s_anode     <= 4'b1111;
      s_cathode   <= 8'hFF;
      run_len     <= 4'd0;
      acc         <= 1'b0;
      seen        <= 4'b0000;
      slot        <= '0;
      idle_cnt    <= 16'd0;
      state       <= IDLE;
      value       <= 16'h0000;
      value_valid <= 1'b0;
      digit_err   <= 1'b0;
      multi_err   <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      s_anode     <= anode;
      s_cathode   <= cathode;
      run_len     <= run_nxt;
      acc         <= acc_nxt;
      seen        <= seen_nxt;
      slot        <= slot_nxt;
      idle_cnt    <= idle_nxt;
      state       <= state_nxt;
      value       <= value_nxt;
      value_valid <= vv_nxt;
      digit_err   <= de_nxt;
      multi_err   <= me_nxt;
      timeout     <= to_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: one instance with STABLE_CYCLES=1 and one with 3,
// driven as an emulated scanning display; frames checked against an expected queue.
module tb_seg7_scan_capture;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  anode, b_anode;
  logic [7:0]  cathode, b_cathode;
  logic [15:0] value, b_value;
  logic        value_valid, digit_err, multi_err, timeout;
  logic        b_vv, b_de, b_me, b_to;

  seg7_scan_capture #(.STABLE_CYCLES(1), .TIMEOUT_CYCLES(64)) dut (
    .clock(clock), .reset_n(reset_n), .anode(anode), .cathode(cathode),
    .value(value), .value_valid(value_valid), .digit_err(digit_err),
    .multi_err(multi_err), .timeout(timeout)
  );

  seg7_scan_capture #(.STABLE_CYCLES(3), .TIMEOUT_CYCLES(64)) dut_b (
    .clock(clock), .reset_n(reset_n), .anode(b_anode), .cathode(b_cathode),
    .value(b_value), .value_valid(b_vv), .digit_err(b_de),
    .multi_err(b_me), .timeout(b_to)
  );

  // clock / reset
  always #5 clock = ~clock;

  // scoreboard state
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic [15:0] got_b[$];
  int          vv_cyc[$];
  int cyc = 0, vectors = 0, miscompares = 0;
  int de_cnt = 0, me_cnt = 0, to_cnt = 0, to_cyc = -1;
  int b_err_cnt = 0, b_vv_cyc = -1, excl_bad = 0;
  int first_c3, c2, cb;

  function automatic logic [7:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 8'h03; 4'h1: seg = 8'h9F; 4'h2: seg = 8'h25; 4'h3: seg = 8'h0D;
      4'h4: seg = 8'h99; 4'h5: seg = 8'h49; 4'h6: seg = 8'h41; 4'h7: seg = 8'h1F;
      4'h8: seg = 8'h01; 4'h9: seg = 8'h09;
      default: seg = 8'hFF;
    endcase
  endfunction

  function automatic logic [3:0] an(input int i);
    logic [3:0] one;
    one = 4'b0001 << i;
    an = ~one;
  endfunction

  // One clock: outputs sampled 1 time unit after the rising edge and logged.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (value_valid) begin
      got_q.push_back(value);
      vv_cyc.push_back(cyc);
    end
    de_cnt += int'(digit_err);
    me_cnt += int'(multi_err);
    if (timeout) begin
      to_cnt++;
      to_cyc = cyc;
    end
    if (int'(digit_err) + int'(multi_err) + int'(timeout) > 1) excl_bad++;
    if (b_vv) begin
      got_b.push_back(b_value);
      b_vv_cyc = cyc;
    end
    b_err_cnt += int'(b_de) + int'(b_me) + int'(b_to);
  endtask

  // driver tasks
  task automatic put(input logic [3:0] a, input logic [7:0] c);
    anode = a;
    cathode = c;
    tick();
  endtask

  task automatic put_b(input logic [3:0] a, input logic [7:0] c);
    b_anode = a;
    b_cathode = c;
    tick();
  endtask

  task automatic dig(input int i, input logic [3:0] n);
    put(an(i), seg(n));
  endtask

  task automatic scan(input logic [15:0] v);
    for (int i = 0; i < 4; i++) dig(i, v[4*i +: 4]);
  endtask

  task automatic idle(input int n);
    repeat (n) put(4'hF, 8'hFF);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_frames(input string tag);
    chk({tag, "_frames"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk({tag, "_value"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    reset_n = 1'b0;
    anode = 4'hF; cathode = 8'hFF;
    b_anode = 4'hF; b_cathode = 8'hFF;
    idle(2);
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_valid", 32'(value_valid), 32'h0);
    chk("rst_digit_err", 32'(digit_err), 32'h0);
    chk("rst_multi_err", 32'(multi_err), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    chk("rst_b_value", 32'(b_value), 32'h0);
    reset_n = 1'b1;

    // loopback scan of 1234, three full frames
    scan(16'h1234);
    first_c3 = cyc;
    scan(16'h1234);
    scan(16'h1234);
    idle(1);
    chk("loop_latency", 32'(vv_cyc[0]), 32'(first_c3 + 1));
    chk("loop_gap1", 32'(vv_cyc[1] - vv_cyc[0]), 32'd4);
    chk("loop_gap2", 32'(vv_cyc[2] - vv_cyc[1]), 32'd4);
    repeat (3) exp_q.push_back(16'h1234);
    check_frames("loop");

    // roll change mid-scan: one mixed frame, then the new value, then all blanks
    dig(0, 4'h4); dig(1, 4'h3); dig(2, 4'h9); dig(3, 4'h0);
    scan(16'h0987);
    scan(16'hFFFF);
    idle(1);
    exp_q.push_back(16'h0934);
    exp_q.push_back(16'h0987);
    exp_q.push_back(16'hFFFF);
    check_frames("roll");
    chk("clean_digit_err", 32'(de_cnt), 32'd0);
    chk("clean_multi_err", 32'(me_cnt), 32'd0);
    chk("clean_timeout", 32'(to_cnt), 32'd0);

    // bad pattern on digit 0 blocks completion until digit 0 is seen valid
    dig(1, 4'h1); dig(2, 4'h2); dig(3, 4'h3);
    put(4'b1110, 8'hAA);
    idle(2);
    chk("derr_pulse", 32'(de_cnt), 32'd1);
    chk("derr_noframe", 32'(got_q.size()), 32'd0);
    dig(0, 4'h4);
    idle(1);
    exp_q.push_back(16'h3214);
    check_frames("derr_fix");

    // bad pattern after a valid digit 0 leaves slot 0 intact
    dig(0, 4'h7);
    put(4'b1110, 8'hAA);
    dig(1, 4'h1); dig(2, 4'h2); dig(3, 4'h3);
    idle(1);
    exp_q.push_back(16'h3217);
    check_frames("derr_keep");
    chk("derr_pulse2", 32'(de_cnt), 32'd2);

    // two anodes low restarts the frame
    dig(0, 4'h9); dig(1, 4'h1); dig(2, 4'h2);
    put(4'b1100, 8'h49);
    dig(3, 4'h8);
    idle(1);
    chk("multi_pulse", 32'(me_cnt), 32'd1);
    chk("multi_noframe", 32'(got_q.size()), 32'd0);
    chk("multi_no_derr", 32'(de_cnt), 32'd2);
    dig(0, 4'h5); dig(1, 4'h6); dig(2, 4'h7);
    idle(1);
    exp_q.push_back(16'h8765);
    check_frames("multi_next");

    // partial frame times out 64 cycles after the last accept is applied
    dig(0, 4'h1); dig(1, 4'h2); dig(2, 4'h3);
    c2 = cyc;
    idle(70);
    chk("to_pulses", 32'(to_cnt), 32'd1);
    chk("to_cycle", 32'(to_cyc), 32'(c2 + 65));
    chk("to_value_held", 32'(value), 32'h8765);
    chk("to_noframe", 32'(got_q.size()), 32'd0);

    // reset in the middle of a frame discards the partial digits
    dig(0, 4'h1); dig(1, 4'h2); dig(2, 4'h3);
    reset_n = 1'b0;
    idle(1);
    chk("mrst_value", 32'(value), 32'h0);
    chk("mrst_flags", {28'd0, value_valid, digit_err, multi_err, timeout}, 32'h0);
    reset_n = 1'b1;
    dig(3, 4'h4);
    idle(2);
    chk("mrst_noframe", 32'(got_q.size()), 32'd0);
    dig(0, 4'h1); dig(1, 4'h2); dig(2, 4'h3);
    idle(1);
    exp_q.push_back(16'h4321);
    check_frames("mrst_next");

    // STABLE_CYCLES=3: 3-cycle holds separated by 1-cycle glitches
    cb = 0;
    for (int i = 0; i < 4; i++) begin
      put_b(an(i), seg(4'(i + 5)));
      if (i == 3) cb = cyc;
      put_b(an(i), seg(4'(i + 5)));
      put_b(an(i), seg(4'(i + 5)));
      if (i < 3) put_b(an(i + 1), 8'hAA);
    end
    repeat (4) put_b(4'hF, 8'hFF);
    chk("stab_frames", 32'(got_b.size()), 32'd1);
    chk("stab_value", 32'(got_b[0]), 32'h8765);
    chk("stab_latency", 32'(b_vv_cyc), 32'(cb + 3));
    chk("stab_no_errors", 32'(b_err_cnt), 32'd0);
    chk("err_exclusive", 32'(excl_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
